ldpc_frame_ctrl: RTL and testbench
==================================

LDPC_FRAME_CTRL -- requirements
Module: ldpc_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 5, LLR width in bits.
REQ-002 SHALL have parameter N_VAR, default 2304, variable nodes per frame (R*D of decoder core).
REQ-003 SHALL have parameter IN_LANES, default 16, LLRs per input beat; N_VAR divisible by IN_LANES.
REQ-004 SHALL have parameter OUT_LANES, default 32, result bits per output beat; N_VAR divisible by OUT_LANES.
REQ-005 SHALL have parameter TIMEOUT, default 40, max DECODE cycles before forced stop (>=1).
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1, in_llr in IN_LANES*DATA_W: LLR input stream, lane 0 at LSBs.
REQ-009 SHALL have port core_l  out  N_VAR*DATA_W  frame LLR buffer driving the core.
REQ-010 SHALL have ports core_en out 1 and core_clr out 1: core enable and core clear (clear active-high).
REQ-011 SHALL have ports core_term in 1, core_err in 1, core_res in N_VAR: core status and hard decisions.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1, out_data out OUT_LANES, out_last out 1, out_err out 1, out_tmo out 1: result stream.
REQ-013 SHALL have ports busy out 1 (state != IDLE) and cyc_cnt out 8 (DECODE cycles of last/current frame, saturating at 255).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CLEAR, DECODE, DRAIN.
REQ-015 SHALL assert in_ready only in IDLE and LOAD; a beat transfers when in_valid && in_ready.
REQ-016 SHALL write beat k (0-based) into core_l LLR slots k*IN_LANES .. k*IN_LANES+IN_LANES-1; slots not yet written keep prior value.
REQ-017 SHALL go IDLE->LOAD on first accepted beat, or IDLE->CLEAR directly if N_VAR==IN_LANES.
REQ-018 SHALL go LOAD->CLEAR on the cycle the beat N_VAR/IN_LANES-1 is accepted; beat counter then wraps to 0.
REQ-019 SHALL hold core_clr=1 for exactly the one CLEAR cycle, core_en=0, then go to DECODE.
REQ-020 SHALL hold core_en=1 throughout DECODE and 0 in every other state.
REQ-021 SHALL clear cyc_cnt on CLEAR and increment it each DECODE cycle, saturating at 255.
REQ-022 SHALL, in DECODE, on first cycle core_term==1: latch core_res into result register, out_err<=core_err, out_tmo<=0, go to DRAIN.
REQ-023 SHALL, in DECODE, if core_term==0 and DECODE cycle count reaches TIMEOUT: latch core_res, out_err<=1, out_tmo<=1, go to DRAIN.
REQ-024 SHALL give core_term priority over timeout when both occur in the same cycle.
REQ-025 SHALL assert out_valid only in DRAIN; out_data=result bits j*OUT_LANES..j*OUT_LANES+OUT_LANES-1 for beat j.
REQ-026 SHALL hold out_data, out_last stable while out_valid && !out_ready; beat advances only on out_valid && out_ready.
REQ-027 SHALL assert out_last on beat N_VAR/OUT_LANES-1 and go DRAIN->IDLE when it is accepted.
REQ-028 SHALL keep out_err, out_tmo stable from latch until next frame's latch.
REQ-029 SHALL ignore in_valid in CLEAR, DECODE, DRAIN (no write to core_l).

Reset
REQ-030 SHALL, on rst low, asynchronously force state IDLE, all counters 0, core_l 0, result register 0, core_en 0, core_clr 0, out_valid 0, out_last 0, out_err 0, out_tmo 0, cyc_cnt 0, busy 0; in_ready=1 after release.
REQ-031 SHALL abandon any in-progress frame on reset mid-operation; no partial output beat emitted after release.

Verification (N_VAR=8, IN_LANES=4, OUT_LANES=4, TIMEOUT=3, DATA_W=5)
REQ-032 SHALL cover: 2 input beats LLRs 1..8, core_term=1 core_err=0 on 2nd DECODE cycle, core_res=8'hA5 -> core_clr one-cycle pulse, out beats 4'h5 then 4'hA (out_last), out_err=0, cyc_cnt=2.
REQ-033 SHALL cover: core_term held 0 -> DRAIN after exactly 3 DECODE cycles, out_err=1, out_tmo=1, core_en low from 4th cycle.
REQ-034 SHALL cover: core_term=1 on 3rd DECODE cycle (coincides with timeout) -> out_tmo=0, out_err=core_err.
REQ-035 SHALL cover: out_ready low 5 cycles during DRAIN -> out_data/out_last stable, no beat lost or repeated.
REQ-036 SHALL cover: in_valid=1 held during DECODE/DRAIN -> in_ready=0, core_l unchanged; in_valid gaps during LOAD -> correct slot placement.
REQ-037 SHALL cover: rst low mid-LOAD and mid-DRAIN -> all outputs at reset values immediately, next frame decodes correctly.

Source files
------------

// File: rtl/ldpc_frame_ctrl.sv
// rtl/ldpc_frame_ctrl.sv - LDPC frame controller: LLR load, core clear/decode with timeout, result drain
module ldpc_frame_ctrl #(
  parameter int DATA_W    = 5,
  parameter int N_VAR     = 2304,
  parameter int IN_LANES  = 16,
  parameter int OUT_LANES = 32,
  parameter int TIMEOUT   = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_LANES*DATA_W-1:0]    in_llr,
  output logic [N_VAR*DATA_W-1:0]       core_l,
  output logic                          core_en,
  output logic                          core_clr,
  input  logic                          core_term,
  input  logic                          core_err,
  input  logic [N_VAR-1:0]              core_res,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_LANES-1:0]          out_data,
  output logic                          out_last,
  output logic                          out_err,
  output logic                          out_tmo,
  output logic                          busy,
  output logic [7:0]                    cyc_cnt
);

  localparam int IN_BEATS  = N_VAR / IN_LANES;
  localparam int OUT_BEATS = N_VAR / OUT_LANES;
  localparam int IN_CW     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int TMO_CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BEAT_W    = IN_LANES * DATA_W;

  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);
  localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]        state;
  logic [IN_CW-1:0]  in_cnt;
  logic [OUT_CW-1:0] out_cnt;
  logic [TMO_CW-1:0] tmo_cnt;
  logic [N_VAR-1:0]  res_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign core_clr  = (state == S_CLEAR);
  assign core_en   = (state == S_DECODE);
  assign out_valid = (state == S_DRAIN);
  assign out_last  = out_valid && (out_cnt == OUT_LAST);
  assign busy      = (state != S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    for (int j = 0; j < OUT_BEATS; j++) begin
      if (out_cnt == OUT_CW'(j)) out_data = res_q[j*OUT_LANES +: OUT_LANES];
    end
  end

  // Only the slot group addressed by the beat counter is written; the rest keep old LLRs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_l <= '0;
    end else if (in_fire) begin
      for (int b = 0; b < IN_BEATS; b++) begin
        if (in_cnt == IN_CW'(b)) core_l[b*BEAT_W +: BEAT_W] <= in_llr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      tmo_cnt <= '0;
      cyc_cnt <= 8'd0;
      res_q   <= '0;
      out_err <= 1'b0;
      out_tmo <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_fire) begin
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              state  <= S_CLEAR;
            end else begin
              in_cnt <= in_cnt + IN_CW'(1);
              state  <= S_LOAD;
            end
          end
        end
        S_CLEAR: begin
          cyc_cnt <= 8'd0;
          tmo_cnt <= '0;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (cyc_cnt != 8'hFF) cyc_cnt <= cyc_cnt + 8'd1;
          // Termination wins over a timeout landing on the same cycle.
          if (core_term) begin
            res_q   <= core_res;
            out_err <= core_err;
            out_tmo <= 1'b0;
            state   <= S_DRAIN;
          end else if (tmo_cnt == TMO_LAST) begin
            res_q   <= core_res;
            out_err <= 1'b1;
            out_tmo <= 1'b1;
            state   <= S_DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_CW'(1);
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (out_cnt == OUT_LAST) begin
              out_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              out_cnt <= out_cnt + OUT_CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// tb/tb_ldpc_frame_ctrl.sv - randomized self-checking bench for ldpc_frame_ctrl against a frame-level model
module tb_ldpc_frame_ctrl;
  localparam int DW  = 5;
  localparam int NV  = 8;
  localparam int IL  = 4;
  localparam int OL  = 4;
  localparam int TO  = 3;
  localparam int NIB = NV / IL;
  localparam int NOB = NV / OL;
  localparam int IW  = IL * DW;
  localparam int LW  = NV * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_llr;
  logic [LW-1:0] core_l;
  logic          core_en;
  logic          core_clr;
  logic          core_term;
  logic          core_err;
  logic [NV-1:0] core_res;
  logic          out_valid;
  logic          out_ready;
  logic [OL-1:0] out_data;
  logic          out_last;
  logic          out_err;
  logic          out_tmo;
  logic          busy;
  logic [7:0]    cyc_cnt;

  ldpc_frame_ctrl #(
    .DATA_W(DW), .N_VAR(NV), .IN_LANES(IL), .OUT_LANES(OL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .core_l(core_l), .core_en(core_en), .core_clr(core_clr),
    .core_term(core_term), .core_err(core_err), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .out_tmo(out_tmo),
    .busy(busy), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int llr_m[NV];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_model();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < NV; i++) v[i*DW +: DW] = DW'(llr_m[i]);
    return v;
  endfunction

  task automatic reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    core_term = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy",     64'(busy),      64'(0));
    chk("rst_in_ready", 64'(in_ready),  64'(1));
    chk("rst_core_en",  64'(core_en),   64'(0));
    chk("rst_core_clr", 64'(core_clr),  64'(0));
    chk("rst_out_valid",64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last),  64'(0));
    chk("rst_out_err",  64'(out_err),   64'(0));
    chk("rst_out_tmo",  64'(out_tmo),   64'(0));
    chk("rst_cyc_cnt",  64'(cyc_cnt),   64'(0));
    chk("rst_core_l",   64'(core_l),    64'(0));
    for (int i = 0; i < NV; i++) llr_m[i] = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    chk("post_rst_busy",      64'(busy),      64'(0));
    chk("post_rst_in_ready",  64'(in_ready),  64'(1));
  endtask

  // rst_mode: 0 none, 1 reset mid-LOAD, 2 reset mid-DRAIN. stall_at >= NOB means no stall.
  task automatic frame(input bit directed, input int term_at, input bit err, input logic [NV-1:0] res,
                       input int stall_at, input int stall_len, input bit gaps, input bit hold,
                       input int rst_mode);
    int exit_k;
    bit exp_tmo;
    bit exp_err;
    int ng;
    logic [IW-1:0] beat;
    exp_tmo = !(term_at >= 1 && term_at <= TO);
    exit_k  = exp_tmo ? TO : term_at;
    exp_err = exp_tmo ? 1'b1 : err;
    for (int b = 0; b < NIB; b++) begin
      ng = gaps ? $urandom_range(0, 2) : 0;
      repeat (ng) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_llr   = IW'($urandom);
      end
      @(negedge clk);
      chk("load_in_ready", 64'(in_ready), 64'(1));
      chk("load_busy",     64'(busy),     64'(b > 0));
      chk("load_core_l",   64'(core_l),   64'(pack_model()));
      if (rst_mode == 1 && b == 1) begin
        reset_pulse();
        return;
      end
      for (int l = 0; l < IL; l++) begin
        beat[l*DW +: DW] = directed ? DW'(b*IL + l + 1) : DW'($urandom);
        llr_m[b*IL + l]  = int'(beat[l*DW +: DW]);
      end
      in_valid = 1'b1;
      in_llr   = beat;
    end
    @(negedge clk);
    in_valid = hold;
    in_llr   = IW'($urandom);
    chk("clear_core_clr",  64'(core_clr), 64'(1));
    chk("clear_core_en",   64'(core_en),  64'(0));
    chk("clear_in_ready",  64'(in_ready), 64'(0));
    chk("clear_core_l",    64'(core_l),   64'(pack_model()));
    for (int k = 1; k <= exit_k; k++) begin
      @(negedge clk);
      chk("dec_core_en",  64'(core_en),  64'(1));
      chk("dec_core_clr", 64'(core_clr), 64'(0));
      chk("dec_in_ready", 64'(in_ready), 64'(0));
      chk("dec_cyc_cnt",  64'(cyc_cnt),  64'(k - 1));
      core_term = (k == term_at);
      core_err  = (k == exit_k) ? err : 1'($urandom);
      core_res  = (k == exit_k) ? res : NV'($urandom);
      in_llr    = IW'($urandom);
    end
    @(negedge clk);
    core_term = 1'b0;
    core_res  = NV'($urandom);
    chk("drain_core_en", 64'(core_en), 64'(0));
    chk("drain_cyc_cnt", 64'(cyc_cnt), 64'(exit_k));
    chk("drain_out_err", 64'(out_err), 64'(exp_err));
    chk("drain_out_tmo", 64'(out_tmo), 64'(exp_tmo));
    chk("drain_core_l",  64'(core_l),  64'(pack_model()));
    for (int j = 0; j < NOB; j++) begin
      if (j == stall_at) begin
        repeat (stall_len) begin
          out_ready = 1'b0;
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_data",  64'(out_data),  64'(res[j*OL +: OL]));
          chk("stall_last",  64'(out_last),  64'(j == NOB - 1));
          @(negedge clk);
        end
      end
      if (rst_mode == 2 && j == 1) begin
        reset_pulse();
        return;
      end
      out_ready = 1'b1;
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_data",  64'(out_data),  64'(res[j*OL +: OL]));
      chk("out_last",  64'(out_last),  64'(j == NOB - 1));
      if (j == NOB - 1) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("idle_busy",      64'(busy),      64'(0));
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_in_ready",  64'(in_ready),  64'(1));
    chk("idle_out_err",   64'(out_err),   64'(exp_err));
    chk("idle_out_tmo",   64'(out_tmo),   64'(exp_tmo));
    chk("idle_core_l",    64'(core_l),    64'(pack_model()));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_llr    = '0;
    core_term = 1'b0;
    core_err  = 1'b0;
    core_res  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NV; i++) llr_m[i] = 0;
    repeat (2) @(negedge clk);
    chk("init_busy",      64'(busy),      64'(0));
    chk("init_out_valid", 64'(out_valid), 64'(0));
    chk("init_core_en",   64'(core_en),   64'(0));
    chk("init_core_l",    64'(core_l),    64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("init_in_ready", 64'(in_ready), 64'(1));
    chk("init_cyc_cnt",  64'(cyc_cnt),  64'(0));

    frame(1'b1, 2, 1'b0, 8'hA5, NOB, 0, 1'b0, 1'b0, 0);
    frame(1'b0, 0, 1'b0, NV'($urandom), NOB, 0, 1'b0, 1'b0, 0);
    frame(1'b0, 3, 1'b1, NV'($urandom), NOB, 0, 1'b0, 1'b0, 0);
    frame(1'b0, 3, 1'b0, NV'($urandom), NOB, 0, 1'b0, 1'b0, 0);
    frame(1'b0, 1, 1'b0, NV'($urandom), 0, 5, 1'b0, 1'b0, 0);
    frame(1'b0, 2, 1'b1, NV'($urandom), 1, 5, 1'b0, 1'b0, 0);
    frame(1'b0, 2, 1'b1, NV'($urandom), NOB, 0, 1'b1, 1'b1, 0);
    frame(1'b0, 2, 1'b0, NV'($urandom), NOB, 0, 1'b0, 1'b0, 1);
    frame(1'b0, 1, 1'b0, NV'($urandom), NOB, 0, 1'b0, 1'b0, 0);
    frame(1'b0, 1, 1'b1, NV'($urandom), NOB, 0, 1'b0, 1'b0, 2);
    frame(1'b0, 2, 1'b0, NV'($urandom), NOB, 0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 10; r++) begin
      frame(1'b0, $urandom_range(0, 4), 1'($urandom), NV'($urandom),
            $urandom_range(0, NOB), $urandom_range(1, 3),
            1'($urandom), 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
